// File: rtl/adc_result_fifo.sv
// Result FIFO behind the ADC: captures a result on each rising edge of conversion_finished_in and serves it on a show-ahead valid/ready port.
// Optional macro ADC_FIFO_TIMESTAMP_EN stores a free-running 16-bit cycle stamp with each entry and adds rd_ts_out.
module adc_result_fifo #(
  parameter int DEPTH     = 8,
  parameter int THRESHOLD = 6
) (
  input  logic                       clk_dig,
  input  logic                       rst,
  input  logic [15:0]                result_in,
  input  logic                       conversion_finished_in,
  input  logic                       conversion_finished_osr_in,
  input  logic                       rd_ready_in,
  output logic                       rd_valid_out,
  output logic [15:0]                rd_data_out,
  output logic                       rd_osr_out,
  input  logic                       flush_in,
  input  logic                       clear_ovf_in,
  output logic [$clog2(DEPTH):0]     count_out,
  output logic                       almost_full_out,
  output logic                       overflow_out,
`ifdef ADC_FIFO_TIMESTAMP_EN
  output logic [15:0]                rd_ts_out,
`endif
  output logic [7:0]                 drop_count_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef ADC_FIFO_TIMESTAMP_EN
  localparam int EW = 33;
`else
  localparam int EW = 17;
`endif

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic          r_fin_q;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_afull;
  logic          r_ovf;
  logic [7:0]    r_drop;
  logic [EW-1:0] r_mem [DEPTH];

  logic          w_push;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_wr;
  logic          w_drop;
  logic [CW-1:0] w_count_nxt;
  logic [EW-1:0] w_entry;
  logic [EW-1:0] w_head;

  assign w_push  = conversion_finished_in & ~r_fin_q;
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = ~w_empty & rd_ready_in & ~flush_in;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_wr    = w_push & ~flush_in & (~w_full | w_pop);
  assign w_drop  = w_push & ~flush_in & w_full & ~w_pop;

`ifdef ADC_FIFO_TIMESTAMP_EN
  logic [15:0] r_ts;

  always_ff @(posedge clk_dig or posedge rst) begin
    if (rst) r_ts <= '0;
    else     r_ts <= r_ts + 16'd1;
  end

  assign w_entry   = {r_ts, conversion_finished_osr_in, result_in};
  assign rd_ts_out = w_empty ? '0 : w_head[32:17];
`else
  assign w_entry = {conversion_finished_osr_in, result_in};
`endif

  always_comb begin
    w_count_nxt = r_count;
    if (flush_in) begin
      w_count_nxt = '0;
    end else begin
      case ({w_wr, w_pop})
        2'b10:   w_count_nxt = r_count + CW'(1);
        2'b01:   w_count_nxt = r_count - CW'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  always_ff @(posedge clk_dig or posedge rst) begin
    if (rst) begin
      r_fin_q  <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_afull  <= 1'b0;
      r_ovf    <= 1'b0;
      r_drop   <= '0;
    end else begin
      r_fin_q <= conversion_finished_in;
      r_count <= w_count_nxt;
      r_afull <= (w_count_nxt >= CW'(THRESHOLD));
      if (flush_in) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      // Clear beats a same-cycle drop for the flag; that drop still counts once.
      if (clear_ovf_in) begin
        r_ovf  <= 1'b0;
        r_drop <= w_drop ? 8'd1 : 8'd0;
      end else if (w_drop) begin
        r_ovf  <= 1'b1;
        r_drop <= sat_inc8(r_drop);
      end
    end
  end

  always_ff @(posedge clk_dig) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_entry;
  end

  assign w_head          = r_mem[r_rd_ptr];
  assign rd_valid_out    = ~w_empty;
  assign rd_data_out     = w_empty ? '0 : w_head[15:0];
  assign rd_osr_out      = w_empty ? 1'b0 : w_head[16];
  assign count_out       = r_count;
  assign almost_full_out = r_afull;
  assign overflow_out    = r_ovf;
  assign drop_count_out  = r_drop;

endmodule
